// File: rtl/ifetch_ctrl_if.sv
// Fetch-controller bus: the PC register port, the IMEM req/ack port and the decode valid/ready port.
// The master side is ifetch_ctrl. The slave side is the surrounding CPU (PC register, IMEM, decode).
interface ifetch_ctrl_if;
    logic [31:0] pc_cur;
    logic        pc_we;
    logic [31:0] pc_next;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ack;
    logic [31:0] im_rdata;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_ready;
    logic        fetch_err;

    modport master (
        input  pc_cur, redirect, redirect_pc, im_ack, im_rdata, inst_ready,
        output pc_we, pc_next, im_req, im_addr, inst, inst_valid, fetch_err
    );
    modport slave (
        output pc_cur, redirect, redirect_pc, im_ack, im_rdata, inst_ready,
        input  pc_we, pc_next, im_req, im_addr, inst, inst_valid, fetch_err
    );
endinterface

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: reads PC, fetches over IMEM req/ack, hands the word to decode,
// then writes PC+4 or a redirect target back to the PC register (which captures on negedge).
module ifetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic          clk,
    input  logic          rst,
    ifetch_ctrl_if.master bus
);
    typedef enum logic [2:0] {IDLE, REQ, HOLD, UPDATE, ERR} state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_nx;
    logic [31:0] fetch_addr, fetch_addr_nx;
    logic [31:0] redir_tgt, redir_tgt_nx;
    logic        squash, squash_nx;
    logic [7:0]  wait_cnt, wait_cnt_nx;
    logic        start;

    logic        pc_we_q, pc_we_nx;
    logic [31:0] pc_next_q, pc_next_nx;
    logic        im_req_q, im_req_nx;
    logic [31:0] im_addr_q, im_addr_nx;
    logic [31:0] inst_q, inst_nx;
    logic        inst_valid_q, inst_valid_nx;
    logic        fetch_err_q, fetch_err_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            fetch_addr   <= '0;
            redir_tgt    <= '0;
            squash       <= 1'b0;
            wait_cnt     <= '0;
            pc_we_q      <= 1'b0;
            pc_next_q    <= RESET_PC;
            im_req_q     <= 1'b0;
            im_addr_q    <= '0;
            inst_q       <= '0;
            inst_valid_q <= 1'b0;
            fetch_err_q  <= 1'b0;
        end else begin
            state        <= state_nx;
            fetch_addr   <= fetch_addr_nx;
            redir_tgt    <= redir_tgt_nx;
            squash       <= squash_nx;
            wait_cnt     <= wait_cnt_nx;
            pc_we_q      <= pc_we_nx;
            pc_next_q    <= pc_next_nx;
            im_req_q     <= im_req_nx;
            im_addr_q    <= im_addr_nx;
            inst_q       <= inst_nx;
            inst_valid_q <= inst_valid_nx;
            fetch_err_q  <= fetch_err_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        fetch_addr_nx = fetch_addr;
        redir_tgt_nx  = redir_tgt;
        squash_nx     = squash;
        wait_cnt_nx   = wait_cnt;
        pc_we_nx      = 1'b0;
        pc_next_nx    = pc_next_q;
        im_req_nx     = im_req_q;
        im_addr_nx    = im_addr_q;
        inst_nx       = inst_q;
        inst_valid_nx = inst_valid_q;
        fetch_err_nx  = fetch_err_q;
        start         = 1'b0;

        case (state)
            IDLE: begin
                if (bus.redirect) begin
                    state_nx   = UPDATE;
                    pc_we_nx   = 1'b1;
                    pc_next_nx = bus.redirect_pc;
                end else begin
                    start = 1'b1;
                end
            end
            REQ: begin
                if (bus.im_ack) begin
                    im_req_nx = 1'b0;
                    // A redirect landing on the ack cycle squashes this word too.
                    if (squash || bus.redirect) begin
                        squash_nx  = 1'b0;
                        state_nx   = UPDATE;
                        pc_we_nx   = 1'b1;
                        pc_next_nx = bus.redirect ? bus.redirect_pc : redir_tgt;
                    end else begin
                        inst_nx       = bus.im_rdata;
                        inst_valid_nx = 1'b1;
                        state_nx      = HOLD;
                    end
                end else begin
                    wait_cnt_nx = wait_cnt + 8'd1;
                    if (bus.redirect) begin
                        squash_nx    = 1'b1;
                        redir_tgt_nx = bus.redirect_pc;
                    end
                    if (wait_cnt == WAIT_LAST) begin
                        state_nx     = ERR;
                        im_req_nx    = 1'b0;
                        fetch_err_nx = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (bus.redirect) begin
                    inst_valid_nx = 1'b0;
                    pc_we_nx      = 1'b1;
                    pc_next_nx    = bus.redirect_pc;
                    state_nx      = UPDATE;
                end else if (bus.inst_ready) begin
                    inst_valid_nx = 1'b0;
                    pc_we_nx      = 1'b1;
                    pc_next_nx    = fetch_addr + 32'd4;
                    state_nx      = UPDATE;
                end
            end
            UPDATE: begin
                if (bus.redirect) begin
                    pc_we_nx   = 1'b1;
                    pc_next_nx = bus.redirect_pc;
                end else begin
                    start = 1'b1;
                end
            end
            ERR: begin
                im_req_nx     = 1'b0;
                inst_valid_nx = 1'b0;
                fetch_err_nx  = 1'b1;
            end
            default: state_nx = IDLE;
        endcase

        // pc_cur is already updated here: the PC register wrote on the previous negedge.
        if (start) begin
            fetch_addr_nx = bus.pc_cur;
            if (bus.pc_cur[1:0] != 2'b00) begin
                state_nx     = ERR;
                fetch_err_nx = 1'b1;
            end else begin
                state_nx    = REQ;
                im_req_nx   = 1'b1;
                im_addr_nx  = bus.pc_cur;
                wait_cnt_nx = '0;
            end
        end
    end

    assign bus.pc_we      = pc_we_q;
    assign bus.pc_next    = pc_next_q;
    assign bus.im_req     = im_req_q;
    assign bus.im_addr    = im_addr_q;
    assign bus.inst       = inst_q;
    assign bus.inst_valid = inst_valid_q;
    assign bus.fetch_err  = fetch_err_q;
endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: directed scenarios then random traffic, checked every cycle against a
// flag-based fetch model; the bench also plays the negedge-written PC register.
module tb_ifetch_ctrl;
    localparam logic [31:0] RESET_PC = 32'h0040_0000;
    localparam int          TIMEOUT  = 255;

    logic clk = 1'b0;
    logic rst;
    ifetch_ctrl_if bus();

    ifetch_ctrl #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] pc_reg;

    // Reference model: what the fetch unit is doing, as independent flags.
    logic        m_req, m_v, m_we, m_err, m_sq;
    logic [31:0] m_pcn, m_addr, m_imaddr, m_inst, m_tgt;
    int          m_wait;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_req = 0; m_v = 0; m_we = 0; m_err = 0; m_sq = 0;
        m_pcn = RESET_PC; m_addr = 0; m_imaddr = 0; m_inst = 0; m_tgt = 0; m_wait = 0;
    endtask

    task automatic model_err();
        m_err = 1; m_req = 0; m_v = 0; m_we = 0;
    endtask

    task automatic model_start(input logic [31:0] p);
        m_addr = p;
        if (p[1:0] != 2'b00) model_err();
        else begin m_req = 1; m_imaddr = p; m_wait = 0; end
    endtask

    task automatic model_edge(input logic rd, input logic [31:0] rpc, input logic ack,
                              input logic [31:0] rdata, input logic rdy, input logic [31:0] pc);
        if (m_err) begin
        end else if (m_we) begin
            if (rd) m_pcn = rpc;
            else begin m_we = 0; model_start(pc); end
        end else if (m_req) begin
            if (ack) begin
                m_req = 0;
                if (m_sq || rd) begin m_sq = 0; m_we = 1; m_pcn = rd ? rpc : m_tgt; end
                else begin m_v = 1; m_inst = rdata; end
            end else begin
                m_wait++;
                if (rd) begin m_sq = 1; m_tgt = rpc; end
                if (m_wait == TIMEOUT) model_err();
            end
        end else if (m_v) begin
            if (rd) begin m_v = 0; m_we = 1; m_pcn = rpc; end
            else if (rdy) begin m_v = 0; m_we = 1; m_pcn = m_addr + 32'd4; end
        end else begin
            if (rd) begin m_we = 1; m_pcn = rpc; end
            else model_start(pc);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc_we"},      {31'b0, bus.pc_we},      {31'b0, m_we});
        chk({tag, ".pc_next"},    bus.pc_next,             m_pcn);
        chk({tag, ".im_req"},     {31'b0, bus.im_req},     {31'b0, m_req});
        chk({tag, ".im_addr"},    bus.im_addr,             m_imaddr);
        chk({tag, ".inst"},       bus.inst,                m_inst);
        chk({tag, ".inst_valid"}, {31'b0, bus.inst_valid}, {31'b0, m_v});
        chk({tag, ".fetch_err"},  {31'b0, bus.fetch_err},  {31'b0, m_err});
    endtask

    // One clock: drive inputs, model the edge, check at negedge, then let the PC register capture.
    task automatic step(input string tag, input logic rd, input logic [31:0] rpc, input logic ack,
                        input logic [31:0] rdata, input logic rdy);
        bus.redirect = rd; bus.redirect_pc = rpc; bus.im_ack = ack;
        bus.im_rdata = rdata; bus.inst_ready = rdy;
        @(posedge clk);
        model_edge(rd, rpc, ack, rdata, rdy, pc_reg);
        @(negedge clk);
        check_all(tag);
        if (bus.pc_we) pc_reg = bus.pc_next;
        bus.pc_cur = pc_reg;
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.redirect = 0; bus.redirect_pc = 0; bus.im_ack = 0; bus.im_rdata = 0; bus.inst_ready = 0;
        pc_reg = RESET_PC; bus.pc_cur = pc_reg;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        rst = 1'b0;
    endtask

    logic        r_rd, r_ack, r_rdy;
    logic [31:0] r_pc;
    int          err_cycles;

    initial begin
        do_reset();

        // 1: first fetch from RESET_PC
        idle("t1_req");
        chk("t1_addr", bus.im_addr, 32'h0040_0000);
        chk("t1_req_hi", {31'b0, bus.im_req}, 32'd1);
        step("t1_ack", 0, 0, 1, 32'h2008_0005, 0);
        chk("t1_inst", bus.inst, 32'h2008_0005);
        chk("t1_valid", {31'b0, bus.inst_valid}, 32'd1);
        step("t1_rdy", 0, 0, 0, 0, 1);
        chk("t1_we", {31'b0, bus.pc_we}, 32'd1);
        chk("t1_pcn", bus.pc_next, 32'h0040_0004);

        // 2: decode stall for 10 cycles
        idle("t2_req");
        chk("t2_addr", bus.im_addr, 32'h0040_0004);
        step("t2_ack", 0, 0, 1, 32'h8C09_0010, 0);
        for (int i = 0; i < 10; i++) begin
            idle("t2_stall");
            chk("t2_stall_valid", {31'b0, bus.inst_valid}, 32'd1);
            chk("t2_stall_inst", bus.inst, 32'h8C09_0010);
            chk("t2_stall_nowr", {30'b0, bus.pc_we, bus.im_req}, 32'd0);
        end
        step("t2_rdy", 0, 0, 0, 0, 1);
        chk("t2_pcn", bus.pc_next, 32'h0040_0008);

        // 3: redirect while the request is outstanding, ack three cycles later
        idle("t3_req");
        step("t3_redir", 1, 32'h0040_0100, 0, 0, 0);
        idle("t3_wait");
        idle("t3_wait");
        step("t3_ack", 0, 0, 1, 32'hDEAD_BEEF, 0);
        chk("t3_valid", {31'b0, bus.inst_valid}, 32'd0);
        chk("t3_we", {31'b0, bus.pc_we}, 32'd1);
        chk("t3_pcn", bus.pc_next, 32'h0040_0100);

        // 4: redirect beats inst_ready in HOLD
        idle("t4_req");
        chk("t4_addr", bus.im_addr, 32'h0040_0100);
        step("t4_ack", 0, 0, 1, 32'h0000_0020, 0);
        step("t4_both", 1, 32'h0040_0200, 0, 0, 1);
        chk("t4_pcn", bus.pc_next, 32'h0040_0200);

        // 6a: PC+4 wraps at the top of the address space
        idle("t6_req");
        step("t6_ack", 0, 0, 1, 32'h1111_1111, 0);
        step("t6_redir", 1, 32'hFFFF_FFFC, 0, 0, 0);
        idle("t6_req2");
        chk("t6_addr", bus.im_addr, 32'hFFFF_FFFC);
        step("t6_ack2", 0, 0, 1, 32'h2222_2222, 0);
        step("t6_rdy", 0, 0, 0, 0, 1);
        chk("t6_wrap", bus.pc_next, 32'h0000_0000);

        // 6b: async reset in REQ, then a stale ack is ignored
        idle("t6b_req");
        chk("t6b_req_hi", {31'b0, bus.im_req}, 32'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t6b_rst_req", {31'b0, bus.im_req}, 32'd0);
        chk("t6b_rst_pcn", bus.pc_next, RESET_PC);
        chk("t6b_rst_addr", bus.im_addr, 32'd0);
        do_reset();
        step("t6b_late_ack", 0, 0, 1, 32'h3333_3333, 0);
        chk("t6b_late_valid", {31'b0, bus.inst_valid}, 32'd0);
        chk("t6b_late_inst", bus.inst, 32'd0);

        // 5a: misaligned redirect target faults at the next REQ entry, sticky until rst
        step("t5_ack", 0, 0, 1, 32'h4444_4444, 0);
        step("t5_redir", 1, 32'h0040_0002, 0, 0, 0);
        idle("t5_err");
        chk("t5_err", {31'b0, bus.fetch_err}, 32'd1);
        chk("t5_noreq", {31'b0, bus.im_req}, 32'd0);
        for (int i = 0; i < 3; i++) step("t5_sticky", 1, 32'h0040_0000, 1, 0, 1);
        chk("t5_still_err", {31'b0, bus.fetch_err}, 32'd1);
        do_reset();

        // 5b: IMEM never acks
        idle("t5b_req");
        for (int i = 0; i < TIMEOUT - 1; i++) idle("t5b_wait");
        chk("t5b_req_last", {31'b0, bus.im_req}, 32'd1);
        chk("t5b_no_err_yet", {31'b0, bus.fetch_err}, 32'd0);
        idle("t5b_to");
        chk("t5b_err", {31'b0, bus.fetch_err}, 32'd1);
        chk("t5b_drop", {31'b0, bus.im_req}, 32'd0);
        do_reset();

        // Random traffic with variable IMEM latency, decode stalls and redirects
        err_cycles = 0;
        for (int i = 0; i < 1500; i++) begin
            r_rd  = ($urandom_range(0, 9) == 0);
            r_pc  = $urandom;
            r_pc[1:0] = ($urandom_range(0, 31) == 0) ? 2'b10 : 2'b00;
            r_ack = bus.im_req && ($urandom_range(0, 2) == 0);
            r_rdy = ($urandom_range(0, 1) == 1);
            step("rnd", r_rd, r_pc, r_ack, $urandom, r_rdy);
            if (m_err) begin
                err_cycles++;
                if (err_cycles == 3) begin do_reset(); err_cycles = 0; end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
